nibble_serial_adder_ctrl: RTL and testbench

Sequencing controller that computes a WIDTH-bit add (and, optionally, subtract) by streaming operands one nibble per cycle through a single 4-bit carry-lookahead slice. The slice exposes group propagate/generate, and this controller carries between nibbles. The block sits between the ALU operand registers and the result bus, and trades latency for area against a full-width CLA tree. It uses a valid/ready handshake on both the operand and result sides.

---
 rtl/nibble_serial_adder_ctrl.sv | 119 +++++++++++
 tb/tb_nibble_serial_adder_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder_ctrl.sv
// Serial WIDTH-bit adder: one nibble per cycle through a single 4-bit CLA slice, valid/ready on both sides.
// Define NIBBLE_ADD_SUB_EN to enable subtraction through the sub input.
module nibble_serial_adder_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(NIB - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] opa, opb, b_eff, sum_nxt;
  logic [IDXW-1:0]  idx;
  logic [IDXW+1:0]  sh;
  logic             carry, carry_init, carry_nxt, last;
  logic [3:0]       na, nb, p, g, c, ss;
  logic             grp_p, grp_g;

`ifdef NIBBLE_ADD_SUB_EN
  assign b_eff      = sub ? ~b : b;
  assign carry_init = sub ? 1'b1 : cin;
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign b_eff      = b;
  assign carry_init = cin;
`endif

  assign sh   = {idx, 2'b00};
  assign na   = 4'(opa >> sh);
  assign nb   = 4'(opb >> sh);
  assign last = (idx == LAST);

  // 4-bit carry-lookahead slice with group propagate/generate
  assign p    = na ^ nb;
  assign g    = na & nb;
  assign c[0] = carry;
  assign c[1] = g[0] | (p[0] & carry);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & carry);
  assign ss   = p ^ c;
  assign grp_p = &p;
  assign grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign carry_nxt = grp_g | (grp_p & carry);

  assign sum_nxt = (sum & ~(WIDTH'(4'hF) << sh)) | (WIDTH'(ss) << sh);

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operands are latched at accept; flags update only on the final nibble so DONE holds them stable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa   <= '0;
      opb   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      zero  <= 1'b0;
      idx   <= '0;
      carry <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            opa   <= a;
            opb   <= b_eff;
            carry <= carry_init;
            idx   <= '0;
          end
        end
        RUN: begin
          sum   <= sum_nxt;
          carry <= carry_nxt;
          idx   <= idx + IDXW'(1);
          if (last) begin
            cout <= carry_nxt;
            ovf  <= (opa[WIDTH-1] == opb[WIDTH-1]) & (ss[3] != opa[WIDTH-1]);
            zero <= (sum_nxt == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Self-checking bench for nibble_serial_adder_ctrl: arithmetic reference model plus per-cycle compare.
// Subtraction cases run only when NIBBLE_ADD_SUB_EN is defined.
module tb_nibble_serial_adder_ctrl;

  localparam int WIDTH = 32;
  localparam int NIB   = WIDTH / 4;
`ifdef NIBBLE_ADD_SUB_EN
  localparam bit SUBEN = 1'b1;
`else
  localparam bit SUBEN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic             sub = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] sum;
  logic             cout, ovf, zero;

  logic       in_valid4 = 1'b0;
  logic       in_ready4;
  logic [3:0] a4 = '0;
  logic [3:0] b4 = '0;
  logic       out_valid4;
  logic [3:0] sum4;
  logic       cout4, ovf4, zero4;

  nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
  );

  nibble_serial_adder_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .cin(1'b0), .sub(1'b0),
    .out_valid(out_valid4), .out_ready(1'b1),
    .sum(sum4), .cout(cout4), .ovf(ovf4), .zero(zero4)
  );

  always #5 clk = ~clk;

  int checkCount = 0;
  int passCount  = 0;
  bit monOn      = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: the result is plain modular arithmetic; timing is accept, NIB busy cycles, then hold
  int               mPhase = 0;
  int               mCount = 0;
  bit               mFresh = 1'b1;
  logic [WIDTH-1:0] mSum = '0;
  logic             mCout = 1'b0, mOvf = 1'b0, mZero = 1'b0;

  task automatic predict(input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb,
                         input logic c, input logic s);
    logic [WIDTH:0]   full;
    logic [WIDTH-1:0] be;
    logic             ci;
    be    = (SUBEN && s) ? ~bb : bb;
    ci    = (SUBEN && s) ? 1'b1 : c;
    full  = {1'b0, aa} + {1'b0, be} + (WIDTH+1)'(ci);
    mSum  = full[WIDTH-1:0];
    mCout = full[WIDTH];
    mOvf  = (aa[WIDTH-1] == be[WIDTH-1]) && (mSum[WIDTH-1] != aa[WIDTH-1]);
    mZero = (mSum == '0);
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mPhase = 0;
      mCount = 0;
      mFresh = 1'b1;
    end else begin
      case (mPhase)
        0: if (in_valid) begin
          predict(a, b, cin, sub);
          mPhase = 1;
          mCount = 0;
          mFresh = 1'b0;
        end
        1: begin
          mCount++;
          if (mCount == NIB) mPhase = 2;
        end
        default: if (out_ready) mPhase = 0;
      endcase
    end
  end

  // Compare process: handshake every cycle, result while held, reset values until the first accept
  always @(negedge clk) begin
    if (monOn) begin
      check("in_ready", 64'(in_ready), 64'(mPhase == 0));
      check("out_valid", 64'(out_valid), 64'(mPhase == 2));
      if (mPhase == 2) begin
        check("sum", 64'(sum), 64'(mSum));
        check("cout", 64'(cout), 64'(mCout));
        check("ovf", 64'(ovf), 64'(mOvf));
        check("zero", 64'(zero), 64'(mZero));
      end else if (mPhase == 0 && mFresh) begin
        check("reset_sum", 64'(sum), 64'(0));
        check("reset_flags", 64'({cout, ovf, zero}), 64'(0));
      end
    end
  end

  task automatic applyStimulus(input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb,
                               input logic c, input logic s);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", 64'(in_ready), 64'(1));
    a = aa; b = bb; cin = c; sub = s; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
  endtask

  task automatic checkOutput(input string name, input logic [WIDTH-1:0] es, input logic ec,
                             input logic eo, input logic ez, output int lat);
    int n;
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    lat = n;
    check({name, "_valid"}, 64'(out_valid), 64'(1));
    check({name, "_sum"}, 64'(sum), 64'(es));
    check({name, "_cout"}, 64'(cout), 64'(ec));
    check({name, "_ovf"}, 64'(ovf), 64'(eo));
    check({name, "_zero"}, 64'(zero), 64'(ez));
  endtask

  function automatic logic [WIDTH-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    rst = 1'b1;
    @(negedge clk);
    monOn = 1'b1;
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);

    applyStimulus(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
    checkOutput("allones_plus_cin", 32'h0000_0000, 1'b1, 1'b0, 1'b1, lat);
    check("latency", 64'(lat), 64'(NIB));

    @(negedge clk);
    applyStimulus(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    checkOutput("signed_ovf", 32'h8000_0000, 1'b0, 1'b1, 1'b0, lat);

    @(negedge clk);
    applyStimulus(32'h1234_5678, 32'h0FED_CBA9, 1'b0, 1'b0);
    checkOutput("ripple_mix", 32'h2222_2221, 1'b0, 1'b0, 1'b0, lat);

`ifdef NIBBLE_ADD_SUB_EN
    @(negedge clk);
    applyStimulus(32'd5, 32'd7, 1'b0, 1'b1);
    checkOutput("sub_neg", 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, lat);
    @(negedge clk);
    applyStimulus(32'h8000_0000, 32'd1, 1'b0, 1'b1);
    checkOutput("sub_ovf", 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, lat);
`endif

    // Backpressure: result held, new operands ignored until release
    @(negedge clk);
    out_ready = 1'b0;
    applyStimulus(32'h0000_00AA, 32'h0000_0055, 1'b0, 1'b0);
    checkOutput("bp_first", 32'h0000_00FF, 1'b0, 1'b0, 1'b0, lat);
    a = 32'd3; b = 32'd4; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    repeat (20) @(negedge clk);
    check("bp_held_sum", 64'(sum), 64'(32'h0000_00FF));
    check("bp_held_ready", 64'(in_ready), 64'(0));
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_idle_ready", 64'(in_ready), 64'(1));
    check("bp_idle_valid", 64'(out_valid), 64'(0));
    @(negedge clk);
    check("bp_second_taken", 64'(in_ready), 64'(0));
    in_valid = 1'b0;
    checkOutput("bp_second", 32'd7, 1'b0, 1'b0, 1'b0, lat);
    check("bp_second_latency", 64'(lat), 64'(NIB));

    // Abort in the fourth busy cycle
    @(negedge clk);
    applyStimulus(32'd1, 32'd2, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_valid", 64'(out_valid), 64'(0));
    check("abort_sum", 64'(sum), 64'(0));
    check("abort_ready", 64'(in_ready), 64'(1));
    check("abort_cout", 64'(cout), 64'(0));
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    applyStimulus(32'd1, 32'd1, 1'b0, 1'b0);
    checkOutput("after_abort", 32'd2, 1'b0, 1'b0, 1'b0, lat);
    check("after_abort_latency", 64'(lat), 64'(NIB));

    // Narrowest instance: one busy cycle
    @(negedge clk);
    a4 = 4'hF; b4 = 4'h1; in_valid4 = 1'b1;
    check("w4_ready", 64'(in_ready4), 64'(1));
    @(negedge clk);
    in_valid4 = 1'b0;
    lat = 1;
    while (!out_valid4 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("w4_latency", 64'(lat), 64'(2));
    check("w4_sum", 64'(sum4), 64'(0));
    check("w4_cout", 64'(cout4), 64'(1));
    check("w4_zero", 64'(zero4), 64'(1));

    // Randomized traffic with random backpressure, checked by the compare process
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 2) == 0);
      a         = pick();
      b         = pick();
      cin       = 1'($urandom);
      sub       = 1'($urandom);
      out_ready = 1'($urandom);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (NIB + 4) @(negedge clk);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
